// File: rtl/game_ctrl.sv
// Stacking-game sequencer: idle/countdown/play/pause/over flow with restart pulse.
// Optional best-score register enabled by GAME_CTRL_HISCORE_EN.
module game_ctrl #(
    parameter int COUNTDOWN_S = 3,
    parameter int OVER_HOLD_S = 5,
    parameter int SCORE_W     = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic               sec_tick,
    input  logic               time_up,
    input  logic [SCORE_W-1:0] score,
    output logic               game_rst,
    output logic               run,
    output logic [2:0]         state,
    output logic [3:0]         countdown,
    output logic [SCORE_W-1:0] hi_score
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    localparam logic [3:0] CD_LOAD   = 4'(COUNTDOWN_S);
    localparam logic [3:0] OVER_LOAD = 4'(OVER_HOLD_S);

    logic       start_q, pause_q;
    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       grst_q, grst_d;
    logic       run_q, run_d;
    logic [3:0] cd_q, cd_d;
    logic       start_rise, pause_rise;

    assign start_rise = start_btn & ~start_q;
    assign pause_rise = pause_btn & ~pause_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grst_d  = 1'b0;
        // A start press restarts the countdown from any state
        if (start_rise) begin
            state_d = S_COUNT;
            cnt_d   = CD_LOAD;
            grst_d  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_COUNT: begin
                    if (sec_tick) begin
                        if (cnt_q == 4'd1) state_d = S_PLAY;
                        else               cnt_d   = cnt_q - 4'd1;
                    end
                end
                S_PLAY: begin
                    if (time_up) begin
                        state_d = S_OVER;
                        cnt_d   = OVER_LOAD;
                    end else if (pause_rise) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (pause_rise) state_d = S_PLAY;
                end
                S_OVER: begin
                    if (sec_tick) begin
                        if (cnt_q == 4'd1) state_d = S_IDLE;
                        else               cnt_d   = cnt_q - 4'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        run_d = (state_d == S_PLAY);
        cd_d  = (state_d == S_COUNT) ? cnt_d : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b1;
            pause_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            grst_q  <= 1'b0;
            run_q   <= 1'b0;
            cd_q    <= 4'd0;
        end else begin
            start_q <= start_btn;
            pause_q <= pause_btn;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grst_q  <= grst_d;
            run_q   <= run_d;
            cd_q    <= cd_d;
        end
    end

    assign game_rst  = grst_q;
    assign run       = run_q;
    assign state     = state_q;
    assign countdown = cd_q;

`ifdef GAME_CTRL_HISCORE_EN
    logic [SCORE_W-1:0] hi_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
        end else if (state_q == S_PLAY && state_d == S_OVER && score > hi_q) begin
            hi_q <= score;
        end
    end

    assign hi_score = hi_q;
`else
    logic unused_score;
    assign unused_score = ^score;
    assign hi_score     = '0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus random
// stimulus compared against a rule-level reference model.
module tb_game_ctrl;

    localparam int CD = 3;
    localparam int OH = 5;
    localparam int SW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_btn = 1'b0;
    logic          pause_btn = 1'b0;
    logic          sec_tick = 1'b0;
    logic          time_up = 1'b0;
    logic [SW-1:0] score = '0;
    logic          game_rst;
    logic          run;
    logic [2:0]    state;
    logic [3:0]    countdown;
    logic [SW-1:0] hi_score;

    int total = 0;
    int bad = 0;

    // reference model (game-level view)
    int m_phase;
    int m_secs;
    bit m_sprev, m_pprev;
    bit m_restart;
    int m_best;

    game_ctrl #(.COUNTDOWN_S(CD), .OVER_HOLD_S(OH), .SCORE_W(SW)) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .pause_btn(pause_btn),
        .sec_tick(sec_tick), .time_up(time_up), .score(score),
        .game_rst(game_rst), .run(run), .state(state),
        .countdown(countdown), .hi_score(hi_score)
    );

    always #5 clk = ~clk;

    function automatic int exp_hi();
`ifdef GAME_CTRL_HISCORE_EN
        return m_best;
`else
        return 0;
`endif
    endfunction

    task automatic model_update(input bit r, s, p, t, tu, input int sc);
        bit sr, pr;
        if (r) begin
            m_phase = 0; m_secs = 0; m_sprev = 1; m_pprev = 1;
            m_restart = 0; m_best = 0;
            return;
        end
        sr = s && !m_sprev;
        pr = p && !m_pprev;
        m_sprev = s;
        m_pprev = p;
        m_restart = 0;
        if (sr) begin
            m_phase = 1; m_secs = CD; m_restart = 1;
        end else if (m_phase == 1) begin
            if (t) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) m_phase = 2;
            end
        end else if (m_phase == 2) begin
            if (tu) begin
                if (sc > m_best) m_best = sc;
                m_phase = 4; m_secs = OH;
            end else if (pr) m_phase = 3;
        end else if (m_phase == 3) begin
            if (pr) m_phase = 2;
        end else if (m_phase == 4) begin
            if (t) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) m_phase = 0;
            end
        end
    endtask

    task automatic step(input bit r, s, p, t, tu, input int sc);
        rst = r; start_btn = s; pause_btn = p; sec_tick = t; time_up = tu;
        score = SW'(sc);
        @(posedge clk);
        model_update(r, s, p, t, tu, sc);
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        total++;
        if (state !== 3'd0 || run !== 1'b0 || game_rst !== 1'b0) begin
            bad++; $display("FAIL reset_ctl state=%0d run=%0b grst=%0b want 0/0/0", state, run, game_rst);
        end
        total++;
        if (countdown !== 4'd0 || hi_score !== '0) begin
            bad++; $display("FAIL reset_val cd=%0d hi=%0d want 0/0", countdown, hi_score);
        end
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        total++;
        if (state !== 3'd0 || game_rst !== 1'b0) begin
            bad++; $display("FAIL start_held state=%0d grst=%0b want 0/0", state, game_rst);
        end
    endtask

    task automatic test_start();
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        total++;
        if (state !== 3'd1 || countdown !== 4'd3 || game_rst !== 1'b1) begin
            bad++; $display("FAIL start_press state=%0d cd=%0d grst=%0b want 1/3/1", state, countdown, game_rst);
        end
        step(0, 1, 0, 0, 0, 0);
        total++;
        if (game_rst !== 1'b0 || state !== 3'd1) begin
            bad++; $display("FAIL grst_width grst=%0b state=%0d want 0/1", game_rst, state);
        end
    endtask

    task automatic test_countdown();
        step(0, 0, 0, 1, 0, 0);
        total++;
        if (countdown !== 4'd2 || state !== 3'd1) begin
            bad++; $display("FAIL cd_tick1 cd=%0d state=%0d want 2/1", countdown, state);
        end
        step(0, 0, 0, 0, 1, 0);
        total++;
        if (countdown !== 4'd2 || state !== 3'd1) begin
            bad++; $display("FAIL cd_timeup_ign cd=%0d state=%0d want 2/1", countdown, state);
        end
        step(0, 0, 0, 1, 0, 0);
        total++;
        if (countdown !== 4'd1) begin
            bad++; $display("FAIL cd_tick2 cd=%0d want 1", countdown);
        end
        step(0, 0, 0, 1, 0, 0);
        total++;
        if (state !== 3'd2 || run !== 1'b1 || countdown !== 4'd0) begin
            bad++; $display("FAIL cd_to_play state=%0d run=%0b cd=%0d want 2/1/0", state, run, countdown);
        end
    endtask

    task automatic test_pause();
        step(0, 0, 1, 0, 0, 0);
        total++;
        if (state !== 3'd3 || run !== 1'b0) begin
            bad++; $display("FAIL pause_in state=%0d run=%0b want 3/0", state, run);
        end
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        total++;
        if (state !== 3'd3 || run !== 1'b0) begin
            bad++; $display("FAIL pause_ignore state=%0d run=%0b want 3/0", state, run);
        end
        step(0, 0, 1, 0, 0, 0);
        total++;
        if (state !== 3'd2 || run !== 1'b1) begin
            bad++; $display("FAIL pause_out state=%0d run=%0b want 2/1", state, run);
        end
    endtask

    task automatic test_over();
        step(0, 0, 1, 0, 1, 17);
        total++;
        if (state !== 3'd4 || run !== 1'b0 || int'(hi_score) !== exp_hi()) begin
            bad++; $display("FAIL over_17 state=%0d run=%0b hi=%0d want 4/0/%0d", state, run, hi_score, exp_hi());
        end
        for (int i = 0; i < OH; i++) begin
            total++;
            if (state !== 3'd4) begin
                bad++; $display("FAIL over_hold tick=%0d state=%0d want 4", i, state);
            end
            step(0, 0, 0, 1, 0, 0);
        end
        total++;
        if (state !== 3'd0) begin
            bad++; $display("FAIL over_to_idle state=%0d want 0", state);
        end
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < CD; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1, 42);
        total++;
        if (state !== 3'd4 || int'(hi_score) !== exp_hi()) begin
            bad++; $display("FAIL over_42 state=%0d hi=%0d want 4/%0d", state, hi_score, exp_hi());
        end
`ifdef GAME_CTRL_HISCORE_EN
        total++;
        if (hi_score !== 7'd42) begin
            bad++; $display("FAIL hi_42 hi=%0d want 42", hi_score);
        end
`endif
    endtask

    task automatic test_priority();
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        total++;
        if (state !== 3'd1 || game_rst !== 1'b1 || int'(hi_score) !== exp_hi()) begin
            bad++; $display("FAIL over_restart state=%0d grst=%0b hi=%0d want 1/1/%0d", state, game_rst, hi_score, exp_hi());
        end
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < CD; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        total++;
        if (state !== 3'd3) begin
            bad++; $display("FAIL prio_setup state=%0d want 3", state);
        end
        step(0, 1, 1, 0, 0, 0);
        total++;
        if (state !== 3'd1 || countdown !== 4'd3 || game_rst !== 1'b1) begin
            bad++; $display("FAIL start_wins state=%0d cd=%0d grst=%0b want 1/3/1", state, countdown, game_rst);
        end
    endtask

    task automatic test_rst_mid();
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        total++;
        if (state !== 3'd0 || countdown !== 4'd0 || game_rst !== 1'b0) begin
            bad++; $display("FAIL rst_mid state=%0d cd=%0d grst=%0b want 0/0/0", state, countdown, game_rst);
        end
        step(0, 0, 0, 0, 0, 0);
        total++;
        if (state !== 3'd0 || game_rst !== 1'b0 || hi_score !== '0) begin
            bad++; $display("FAIL rst_after state=%0d grst=%0b hi=%0d want 0/0/0", state, game_rst, hi_score);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int n = 0; n < 3000; n++) begin
            bit r, s, p, t, tu;
            r  = ($urandom_range(0, 299) == 0);
            s  = ($urandom_range(0, 39) == 0) ? ~start_btn : start_btn;
            p  = ($urandom_range(0, 7) == 0) ? ~pause_btn : pause_btn;
            t  = ($urandom_range(0, 3) == 0);
            tu = ($urandom_range(0, 24) == 0);
            step(r, s, p, t, tu, int'($urandom_range(0, (1 << SW) - 1)));
            total++;
            if (int'(state) !== m_phase || run !== (m_phase == 2) || game_rst !== m_restart
                || int'(countdown) !== ((m_phase == 1) ? m_secs : 0)
                || int'(hi_score) !== exp_hi()) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL rand n=%0d st=%0d run=%0b grst=%0b cd=%0d hi=%0d want %0d/%0b/%0b/%0d/%0d",
                             n, state, run, game_rst, countdown, hi_score, m_phase,
                             m_phase == 2, m_restart, (m_phase == 1) ? m_secs : 0, exp_hi());
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_countdown();
        test_pause();
        test_over();
        test_priority();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
